// File: rtl/pipe_pkg.sv
// Shared types and default widths for pipeline boundary registers.
package pipe_pkg;

    localparam int MEMWB_W     = 112;
    localparam int STALL_CNT_W = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_e;

    // Field order fixes the packed layout carried as an opaque payload.
    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [31:0] data_addr;
        logic        reg_write_valid;
        logic [4:0]  write_reg;
        logic [31:0] reg_write_data;
        logic [31:0] data_read;
    } memwb_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    // NOTE: state is updated with <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline boundary register with valid/ready, flush and stall counter.
// Define PIPE_STAGE_SKID_EN for a 2-entry skid buffer with registered in_ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int WIDTH = MEMWB_W,
    parameter int CNT_W = STALL_CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] stall_cnt
);

    logic in_xfer;
    logic out_xfer;

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

`ifdef PIPE_STAGE_SKID_EN
    skid_state_e      state;
    logic [WIDTH-1:0] skid_data;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            out_data  <= '0;
        end else if (flush) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_xfer) begin
                        state     <= ONE;
                        out_valid <= 1'b1;
                        out_data  <= in_data;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        out_data <= in_data;
                    end else if (in_xfer) begin
                        state    <= TWO;
                        in_ready <= 1'b0;
                    end else if (out_xfer) begin
                        state     <= EMPTY;
                        out_valid <= 1'b0;
                    end
                end
                TWO: begin
                    if (out_xfer) begin
                        state    <= ONE;
                        in_ready <= 1'b1;
                        out_data <= skid_data;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

    // NOTE: the skid slot has no reset; it is only read in TWO, which is
    // reachable solely by an input transfer that has just written it.
    always_ff @(posedge clk) begin
        if (in_xfer) begin
            skid_data <= in_data;
        end
    end
`else
    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (in_xfer) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
        end else if (out_xfer) begin
            out_valid <= 1'b0;
        end
    end
`endif

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (out_valid && !out_ready && !flush),
        .clr     (cnt_clr),
        .count   (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg; skid-specific expectations follow PIPE_STAGE_SKID_EN.
module tb_pipe_stage_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset_n, flush, in_valid, in_ready, out_valid, out_ready, cnt_clr;
    logic [111:0] in_data, out_data;
    logic [15:0]  stall_cnt;

    logic         s_reset_n, s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_cnt_clr;
    logic [7:0]   s_in_data, s_out_data;
    logic [1:0]   s_stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    pipe_stage_reg dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .cnt_clr   (cnt_clr),
        .stall_cnt (stall_cnt)
    );

    pipe_stage_reg #(.WIDTH(8), .CNT_W(2)) dut_small (
        .clk       (clk),
        .reset_n   (s_reset_n),
        .flush     (s_flush),
        .in_valid  (s_in_valid),
        .in_data   (s_in_data),
        .in_ready  (s_in_ready),
        .out_valid (s_out_valid),
        .out_data  (s_out_data),
        .out_ready (s_out_ready),
        .cnt_clr   (s_cnt_clr),
        .stall_cnt (s_stall_cnt)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam logic [111:0] D0 = 112'h0070_0003;
    localparam logic [111:0] D1 = 112'hABCD_0000_1111_2222_3333_4444_5555;
    localparam logic [111:0] DA = 112'hA;
    localparam logic [111:0] DB = 112'hB;
    localparam logic [111:0] DC = 112'hC;
    localparam logic [111:0] DE = 112'hE;
    localparam logic [111:0] DF = 112'hF;
    localparam logic [111:0] DG = 112'h16;
    localparam logic [111:0] DH = 112'h17;

    logic [1:0] sat_exp [6] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};

    initial begin
        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; cnt_clr = 1'b0;
        s_reset_n = 1'b0; s_flush = 1'b0; s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b0; s_cnt_clr = 1'b0;
        step();
        step();
        reset_n = 1'b1; s_reset_n = 1'b1;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_stall_cnt", stall_cnt, 0);

        // Streaming with simultaneous in/out transfers.
        in_valid = 1'b1; in_data = D0; out_ready = 1'b1;
        #1;
        check("stream_in_ready0", in_ready, 1);
        step();
        check("stream_valid0", out_valid, 1);
        check("stream_data0", out_data, D0);
        check("stream_in_ready1", in_ready, 1);
        in_data = D1;
        step();
        check("stream_valid1", out_valid, 1);
        check("stream_data1", out_data, D1);
        in_valid = 1'b0;
        step();
        check("stream_drain", out_valid, 0);
        check("stream_cnt", stall_cnt, 0);

        // Back-pressure.
        in_valid = 1'b1; in_data = DA; out_ready = 1'b1;
        step();
        check("bp_load_a", out_data, DA);
        out_ready = 1'b0; in_data = DB;
        #1;
`ifdef PIPE_STAGE_SKID_EN
        check("bp_skid_ready", in_ready, 1);
`else
        check("bp_noskid_ready", in_ready, 0);
`endif
        step();
`ifdef PIPE_STAGE_SKID_EN
        in_valid = 1'b0;
`endif
        #1;
        check("bp_ready_full", in_ready, 0);
        for (int i = 0; i < 4; i++) step();
        check("bp_cnt5", stall_cnt, 5);
        check("bp_hold_data", out_data, DA);
        check("bp_hold_valid", out_valid, 1);
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", in_ready, `ifdef PIPE_STAGE_SKID_EN 0 `else 1 `endif);
        step();
        check("bp_second_data", out_data, DB);
        check("bp_second_valid", out_valid, 1);
        in_valid = 1'b0;
        step();
        check("bp_empty", out_valid, 0);
        check("bp_cnt_kept", stall_cnt, 5);
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        check("bp_cnt_clr", stall_cnt, 0);

        // Flush during stall drops the offered input.
        in_valid = 1'b1; in_data = DC; out_ready = 1'b1;
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        step();
        check("fl_pre_cnt", stall_cnt, 1);
        flush = 1'b1; in_valid = 1'b1; in_data = DE;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_valid", out_valid, 0);
        check("fl_cnt", stall_cnt, 1);
        check("fl_in_ready", in_ready, 1);
        check("fl_data_held", out_data, DC);
        out_ready = 1'b1;
        step();
        check("fl_dropped", out_valid, 0);

        // Reset mid-stall (state TWO in skid mode).
        in_valid = 1'b1; in_data = DG; out_ready = 1'b1;
        step();
        out_ready = 1'b0; in_data = DH;
`ifdef PIPE_STAGE_SKID_EN
        step();
        in_valid = 1'b0;
        #1;
`else
        #1;
`endif
        check("mid_full", in_ready, 0);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1; in_valid = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_data", out_data, 0);
        check("mid_rst_ready", in_ready, 1);
        check("mid_rst_cnt", stall_cnt, 0);
        in_valid = 1'b1; in_data = DF; out_ready = 1'b1;
        step();
        check("mid_new_valid", out_valid, 1);
        check("mid_new_data", out_data, DF);
        in_valid = 1'b0;
        step();
        check("mid_drained", out_valid, 0);

        // Saturation with a 2-bit counter.
        s_in_valid = 1'b1; s_in_data = 8'h5A; s_out_ready = 1'b1;
        step();
        s_in_valid = 1'b0; s_out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            check($sformatf("sat_cnt%0d", i), s_stall_cnt, sat_exp[i]);
        end
        check("sat_data", s_out_data, 8'h5A);
        s_cnt_clr = 1'b1;
        step();
        check("sat_clr", s_stall_cnt, 0);
        s_cnt_clr = 1'b0;
        step();
        check("sat_after_clr", s_stall_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline boundary register, the general successor to the fixed MEM/WB latch. It carries an opaque payload of configurable width between two pipeline stages with a valid/ready handshake, back-pressure (stall), synchronous flush (bubble insertion) and a saturating stall-cycle counter. It is instantiated at every stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB). The default width equals the packed MEM/WB field set: opcode 7, funct3 3, data_addr 32, reg_write_valid 1, write_reg 5, reg_write_data 32, data_read 32.

## Interface
- WIDTH, 112: payload width in bits; must be ≥1.
- CNT_W, 16: stall counter width; must be ≥2.
- clk  in  1  rising-edge clock.
- reset_n  in  1  one clock; reset is synchronous and active-low.
- flush  in  1  discard held and incoming entries.
- in_valid  in  1  upstream entry present.
- in_data  in  WIDTH  upstream payload.
- in_ready  out  1  stage accepts this cycle.
- out_valid  out  1  downstream entry present.
- out_data  out  WIDTH  downstream payload.
- out_ready  in  1  downstream accepts this cycle.
- cnt_clr  in  1  clear stall counter.
- stall_cnt  out  CNT_W  saturating count of stalled cycles.

## Operation
- A transfer occurs on a side when its valid and ready are both 1 at a rising edge.
- Priority per edge: reset_n=0, then flush, then normal transfer.
- Reset: out_valid=0, out_data=0, in_ready=1, stall_cnt=0, skid empty.
- Flush: next cycle out_valid=0 and the skid is empty. An input offered in the flush cycle is dropped. out_data is don't-care but is held, not zeroed. in_ready follows the normal rule for the post-flush (empty) state.
- Normal operation without skid:
  - in_ready = !out_valid || out_ready (combinational).
  - On an input transfer: out_data ← in_data, out_valid ← 1.
  - On an output transfer with no input transfer: out_valid ← 0.
- Stall: out_valid=1 and out_ready=0 holds out_data and out_valid unchanged.
- stall_cnt:
  - +1 each cycle with out_valid && !out_ready && !flush.
  - Saturates at 2^CNT_W−1.
  - cnt_clr sets it to 0; if an increment condition coincides, cnt_clr wins.
- Payload bits are never interpreted.

## Timing
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: 1 entry/cycle while out_ready=1.
- No-skid mode has a combinational path out_ready→in_ready.
- Skid mode: in_ready is a register output; no combinational input-to-output path.
- Simultaneous input and output transfer in ONE state: state stays ONE and data is replaced.
- reset_n low for a single cycle fully reinitialises the block, even mid-stall.

## Configuration
- Macro: PIPE_STAGE_SKID_EN.
- Defined: a 2-entry skid buffer with three states.
  - EMPTY, ONE and TWO; in_ready = (state != TWO), registered.
  - EMPTY + input transfer → ONE.
  - ONE + input, no output → TWO; the new entry goes to the skid slot.
  - TWO + output transfer → ONE; the skid slot moves to the main slot.
  - ONE + output only → EMPTY.
  - Order is preserved.
  - Flush → EMPTY.
- Undefined: single register, combinational in_ready as above; no skid storage is synthesised.

## Structure
- Package pipe_pkg holds:
  - the per-boundary packed struct typedefs (e.g. memwb_t, whose $bits is 112);
  - the state enum {EMPTY, ONE, TWO};
  - the localparam default widths.
- One natural sub-module, sat_counter, parametrised by CNT_W with inc/clr inputs, used for stall_cnt.

## Test plan
- Reset then stream: reset_n=0 for 2 cycles, then in_data=0x…0070_0003 with in_valid=1 and out_ready=1. Expect out_valid=1 one cycle later, out_data matching, in_ready=1 throughout.
- Back-pressure:
  - Entry A accepted, then out_ready=0 for 5 cycles. Expect out_data=A held, stall_cnt=5.
  - No-skid mode: in_ready=0.
  - Skid mode: entry B is accepted, then in_ready=0; releasing out_ready yields A then B in order.
- Flush during stall: held entry plus flush=1 with in_valid=1. Next cycle out_valid=0, the input is dropped and stall_cnt is unchanged.
- Saturation: CNT_W=2 with a 6-cycle stall. Expect stall_cnt sequence 1,2,3,3,3,3. cnt_clr asserted with a stall gives 0.
- Reset mid-operation: skid mode in state TWO, then reset_n=0 for 1 cycle. Expect out_valid=0, in_ready=1, stall_cnt=0, and the first new entry emerges as the next output.
